// File: rtl/ctrl_pipe_regs.sv
// Control-side pipeline registers ID/EX, EX/MEM and MEM/WB, with load-use stall,
// branch/jump flush and EX-stage forwarding selects.
module ctrl_pipe_regs #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_RegDst,
  input  logic             id_ALUSrc,
  input  logic             id_MemtoReg,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_Branch,
  input  logic             id_Jump,
  input  logic [1:0]       id_ALUOp,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_zero,
  output logic             stall,
  output logic             flush,
  output logic             ex_ALUSrc,
  output logic [1:0]       ex_ALUOp,
  output logic             ex_Branch,
  output logic             ex_Jump,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic             wb_RegWrite,
  output logic             wb_MemtoReg,
  output logic [REG_W-1:0] wb_dst
);

  typedef struct packed {
    logic             v;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src;
    logic             branch;
    logic             jump;
    logic [1:0]       alu_op;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } ex_stage_t;

  typedef struct packed {
    logic             v;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic [REG_W-1:0] dst;
  } mem_stage_t;

  typedef struct packed {
    logic             v;
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] dst;
  } wb_stage_t;

  ex_stage_t  ex_q,  ex_d;
  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q,  wb_d;

  logic             uses_rs;
  logic             uses_rt;
  logic             load_use;
  logic             flush_w;
  logic             stall_w;
  logic [REG_W-1:0] id_dst;

  // A non-writing instruction carries dst=0 so a don't-care RegDst can never
  // create a false hazard or forwarding match downstream.
  always_comb begin
    id_dst = '0;
    if (id_RegWrite) begin
      id_dst = id_RegDst ? id_rd : id_rt;
    end
  end

  always_comb begin
    uses_rs  = ~id_Jump;
    uses_rt  = id_RegDst | id_MemWrite | (id_Branch & ~id_Jump);
    flush_w  = ex_q.v & ex_q.branch & (ex_q.jump | ex_zero);
    load_use = id_valid & ex_q.v & ex_q.mem_read & (ex_q.dst != '0) &
               ((uses_rs & (ex_q.dst == id_rs)) | (uses_rt & (ex_q.dst == id_rt)));
    // A taken branch discards the ID instruction anyway, so it cannot stall.
    stall_w  = load_use & ~flush_w;
  end

  always_comb begin
    ex_d = '0;
    if (id_valid & ~stall_w & ~flush_w) begin
      ex_d.v          = 1'b1;
      ex_d.reg_write  = id_RegWrite;
      ex_d.mem_to_reg = id_MemtoReg;
      ex_d.mem_read   = id_MemRead;
      ex_d.mem_write  = id_MemWrite;
      ex_d.alu_src    = id_ALUSrc;
      ex_d.branch     = id_Branch;
      ex_d.jump       = id_Jump;
      ex_d.alu_op     = id_ALUOp;
      ex_d.dst        = id_dst;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
    end
  end

  always_comb begin
    mem_d            = '0;
    mem_d.v          = ex_q.v;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.dst        = ex_q.dst;
  end

  always_comb begin
    wb_d            = '0;
    wb_d.v          = mem_q.v;
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.dst        = mem_q.dst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  logic [REG_W-1:0] fwd_src [2];
  logic [1:0]       fwd_sel [2];

  assign fwd_src[0] = ex_q.rs;
  assign fwd_src[1] = ex_q.rt;

  // The younger producer in MEM shadows an older one in WB for the same register.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;
      assign mem_hit = mem_q.v & mem_q.reg_write & (mem_q.dst != '0) & (mem_q.dst == fwd_src[gi]);
      assign wb_hit  = wb_q.v & wb_q.reg_write & (wb_q.dst != '0) & (wb_q.dst == fwd_src[gi]);
      assign fwd_sel[gi] = mem_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
    end
  endgenerate

  assign stall        = stall_w;
  assign flush        = flush_w;
  assign fwd_a        = fwd_sel[0];
  assign fwd_b        = fwd_sel[1];
  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_ALUOp     = ex_q.alu_op;
  assign ex_Branch    = ex_q.branch;
  assign ex_Jump      = ex_q.jump;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign mem_MemRead  = mem_q.v & mem_q.mem_read;
  assign mem_MemWrite = mem_q.v & mem_q.mem_write;
  assign wb_RegWrite  = wb_q.v & wb_q.reg_write;
  assign wb_MemtoReg  = wb_q.mem_to_reg;
  assign wb_dst       = wb_q.dst;

endmodule
